// File: rtl/aes128_key_pkg.sv
// Shared sizes and types for the AES-128 key loader.
package aes128_key_pkg;
  localparam int KeyWidth    = 128;
  localparam int WordWidth   = 32;
  localparam int WordsPerKey = 4;

  typedef enum logic [1:0] {COLLECT, COMMIT, LOCKED} key_loader_state_e;
  typedef logic [1:0] word_cnt_t;
endpackage

// File: rtl/aes128_key_loader.sv
// Collects four 32-bit key words (MSW first) and issues a single write to the
// AES-128 key register, with framing-error detection, abort and a sticky lock.
module aes128_key_loader
  import aes128_key_pkg::*;
#(
  parameter logic LockEnable = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [WordWidth-1:0] word_i,
  input  logic                 word_last_i,
  input  logic                 abort_i,
  input  logic                 lock_i,
  output logic                 key_we_o,
  output logic [KeyWidth-1:0]  key_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 locked_o
);

  key_loader_state_e   state_q, state_d;
  word_cnt_t           cnt_q, cnt_d;
  logic [KeyWidth-1:0] stage_q, stage_d;
  logic                lock_req_q, lock_req_d;
  logic                err_q, err_d;
  logic                accept;
  logic                last_beat;

  assign word_ready_o = (state_q == COLLECT) && !abort_i;
  assign accept       = word_valid_i && word_ready_o;
  assign last_beat    = (cnt_q == word_cnt_t'(WordsPerKey - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    err_d      = 1'b0;
    lock_req_d = lock_req_q | lock_i;
    unique case (state_q)
      COLLECT: begin
        if (abort_i) begin
          cnt_d   = '0;
          stage_d = '0;
        end else if (accept) begin
          // word_last_i must appear on exactly the fourth beat
          if (word_last_i != last_beat) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            stage_d[{~cnt_q, 5'b0} +: WordWidth] = word_i;
            if (word_last_i) state_d = COMMIT;
            else             cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      COMMIT: begin
        cnt_d   = '0;
        stage_d = '0;
        state_d = (LockEnable && lock_req_q) ? LOCKED : COLLECT;
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      stage_q    <= '0;
      lock_req_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      lock_req_q <= lock_req_d;
      err_q      <= err_d;
    end
  end

  // Staged material only reaches key_o during the write strobe.
  assign key_we_o = (state_q == COMMIT);
  assign key_o    = key_we_o ? stage_q : '0;
  assign busy_o   = (cnt_q != '0) || (state_q == COMMIT);
  assign err_o    = err_q;
  assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_aes128_key_loader.sv
// Randomized and directed bench for aes128_key_loader, checked against a
// word-queue model of the loader.
module tb_aes128_key_loader;
  import aes128_key_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld = 1'b0, last = 1'b0, ab = 1'b0, lk = 1'b0;
  logic [31:0]  wd = '0;
  logic         rdy1, we1, busy1, err1, lck1;
  logic [127:0] key1;
  logic         rdy0, we0, busy0, err0, lck0;
  logic [127:0] key0;

  int total = 0;
  int bad   = 0;

  // Model: words held so far, plus commit/lock/error flags for the current cycle
  logic [31:0]  mq[$];
  bit           m_commit, m_locked, m_lreq, m_err;
  logic         e_rdy, e_we, e_busy, e_err, e_lck;
  logic [127:0] e_key;

  always #5 clk = ~clk;

  aes128_key_loader #(.LockEnable(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .word_valid_i(vld), .word_ready_o(rdy1),
    .word_i(wd), .word_last_i(last), .abort_i(ab), .lock_i(lk),
    .key_we_o(we1), .key_o(key1), .busy_o(busy1), .err_o(err1), .locked_o(lck1));

  aes128_key_loader #(.LockEnable(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .word_valid_i(vld), .word_ready_o(rdy0),
    .word_i(wd), .word_last_i(last), .abort_i(ab), .lock_i(lk),
    .key_we_o(we0), .key_o(key0), .busy_o(busy0), .err_o(err0), .locked_o(lck0));

  task automatic model_reset();
    mq.delete();
    m_commit = 0; m_locked = 0; m_lreq = 0; m_err = 0;
  endtask

  // Drive one cycle's inputs at negedge; publish expected outputs for this
  // cycle, then advance the model past the coming posedge.
  task automatic step(input logic v, input logic [31:0] w, input logic l,
                      input logic a, input logic k);
    @(negedge clk);
    vld = v; wd = w; last = l; ab = a; lk = k;
    #1;
    e_rdy  = !m_commit && !m_locked && !a;
    e_we   = m_commit;
    e_key  = m_commit ? {mq[0], mq[1], mq[2], mq[3]} : 128'h0;
    e_busy = (mq.size() != 0);
    e_err  = m_err;
    e_lck  = m_locked;
    m_err  = 0;
    if (m_locked) begin
    end else if (m_commit) begin
      mq.delete();
      m_commit = 0;
      m_locked = m_lreq;
    end else if (a) begin
      mq.delete();
    end else if (v) begin
      if (l != (mq.size() == 3)) begin
        m_err = 1;
        mq.delete();
      end else begin
        mq.push_back(w);
        m_commit = l;
      end
    end
    m_lreq = m_lreq | k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({rdy1, we1, busy1, err1, lck1} !== 5'b10000 || key1 !== 128'h0) begin
      bad++; $display("FAIL reset_outputs got rdy/we/busy/err/lck=%b key=%h want 10000 key=0",
                      {rdy1, we1, busy1, err1, lck1}, key1);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] w[4];
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090A0B; w[3] = 32'h0C0D0E0F;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], i == 3, 1'b0, 1'b0);
      total++;
      if (rdy1 !== 1'b1 || we1 !== 1'b0) begin
        bad++; $display("FAIL basic_beat%0d got rdy=%b we=%b want rdy=1 we=0", i, rdy1, we1);
      end
      if (i < 3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (we1 !== 1'b1 || key1 !== 128'h000102030405060708090A0B0C0D0E0F || busy1 !== 1'b1) begin
      bad++; $display("FAIL basic_commit got we=%b busy=%b key=%h want we=1 busy=1 key=000102030405060708090a0b0c0d0e0f",
                      we1, busy1, key1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (we1 !== 1'b0 || key1 !== 128'h0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL basic_after got we=%b busy=%b key=%h want we=0 busy=0 key=0", we1, busy1, key1);
    end
  endtask

  // valid held high throughout, including the commit cycle
  task automatic test_back_to_back();
    logic [31:0] w[8];
    int p = 0, commits = 0;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    for (int c = 0; c < 30 && !(p == 8 && commits == 2); c++) begin
      step(p < 8, p < 8 ? w[p] : 32'h0, (p % 4) == 3, 1'b0, 1'b0);
      total++;
      if (rdy1 !== e_rdy || we1 !== e_we || key1 !== e_key) begin
        bad++; $display("FAIL b2b_cycle%0d got rdy=%b we=%b key=%h want rdy=%b we=%b key=%h",
                        c, rdy1, we1, key1, e_rdy, e_we, e_key);
      end
      if (we1 === 1'b1) begin
        total++;
        if (key1 !== (commits == 0 ? {w[0], w[1], w[2], w[3]} : {w[4], w[5], w[6], w[7]})) begin
          bad++; $display("FAIL b2b_key%0d got %h", commits, key1);
        end
        commits++;
      end
      if (vld && rdy1 === 1'b1) p++;
    end
    total++;
    if (commits != 2) begin
      bad++; $display("FAIL b2b_commits got %0d want 2", commits);
    end
  endtask

  task automatic test_framing();
    logic [31:0] w[4];
    int seen_we = 0;
    step(1'b1, 32'hAAAA0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (err1 !== 1'b1 || we1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL frame_early_last got err=%b we=%b busy=%b want 1 0 0", err1, we1, busy1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (err1 !== 1'b0) begin
      bad++; $display("FAIL frame_err_width got err=%b want 0", err1);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 32'hBBBB0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (err1 !== 1'b1 || we1 !== 1'b0) begin
      bad++; $display("FAIL frame_missing_last got err=%b we=%b want 1 0", err1, we1);
    end
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      step(i < 4, i < 4 ? w[i] : 32'h0, i == 3, 1'b0, 1'b0);
      if (we1 === 1'b1) begin
        seen_we++;
        total++;
        if (key1 !== {w[0], w[1], w[2], w[3]} || key1 !== e_key) begin
          bad++; $display("FAIL frame_recover_key got %h want %h", key1, {w[0], w[1], w[2], w[3]});
        end
      end
    end
    total++;
    if (seen_we != 1) begin
      bad++; $display("FAIL frame_recover_we got %0d strobes want 1", seen_we);
    end
  endtask

  task automatic test_abort();
    logic [31:0] w[4];
    step(1'b1, 32'hDEAD0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0002, 1'b0, 1'b1, 1'b0);
    total++;
    if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++; $display("FAIL abort_ready got rdy=%b busy=%b want 0 1", rdy1, busy1);
    end
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      step(i < 4, i < 4 ? w[i] : 32'h0, i == 3, 1'b0, 1'b0);
      if (i == 0) begin
        total++;
        if (busy1 !== 1'b0 || err1 !== 1'b0) begin
          bad++; $display("FAIL abort_cleared got busy=%b err=%b want 0 0", busy1, err1);
        end
      end
    end
    total++;
    if (we1 !== 1'b1 || key1 !== {w[0], w[1], w[2], w[3]}) begin
      bad++; $display("FAIL abort_newkey got we=%b key=%h want 1 %h", we1, key1, {w[0], w[1], w[2], w[3]});
    end
  endtask

  task automatic test_random();
    logic v, l, a;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 4) != 0;
      l = (mq.size() == 3) ? (($urandom % 8) != 0) : (($urandom % 10) == 0);
      a = ($urandom % 16) == 0;
      step(v, $urandom, l, a, 1'b0);
      total++;
      if (rdy1 !== e_rdy || we1 !== e_we || key1 !== e_key || busy1 !== e_busy ||
          err1 !== e_err || lck1 !== e_lck) begin
        bad++; $display("FAIL rand_dut1 c=%0d got rdy/we/busy/err/lck=%b%b%b%b%b key=%h want %b%b%b%b%b key=%h",
                        c, rdy1, we1, busy1, err1, lck1, key1, e_rdy, e_we, e_busy, e_err, e_lck, e_key);
      end
      total++;
      if (rdy0 !== e_rdy || we0 !== e_we || key0 !== e_key || busy0 !== e_busy ||
          err0 !== e_err || lck0 !== e_lck) begin
        bad++; $display("FAIL rand_dut0 c=%0d got rdy/we/busy/err/lck=%b%b%b%b%b key=%h want %b%b%b%b%b key=%h",
                        c, rdy0, we0, busy0, err0, lck0, key0, e_rdy, e_we, e_busy, e_err, e_lck, e_key);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vld = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if ({rdy1, we1, busy1, err1, lck1} !== 5'b10000 || key1 !== 128'h0) begin
      bad++; $display("FAIL reset_mid got rdy/we/busy/err/lck=%b key=%h want 10000 key=0",
                      {rdy1, we1, busy1, err1, lck1}, key1);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (we1 !== 1'b0 || busy1 !== 1'b0) strobes++;
    end
    total++;
    if (strobes != 0) begin
      bad++; $display("FAIL reset_mid_nowrite got %0d bad cycles want 0", strobes);
    end
  endtask

  task automatic test_lock();
    logic [31:0] w[4];
    int leaks = 0;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) step(1'b1, w[i], i == 3, 1'b0, i == 1);
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    total++;
    if (we1 !== 1'b1 || key1 !== {w[0], w[1], w[2], w[3]} || we0 !== 1'b1) begin
      bad++; $display("FAIL lock_commit got we1=%b we0=%b key=%h want 1 1 %h",
                      we1, we0, key1, {w[0], w[1], w[2], w[3]});
    end
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    total++;
    if (lck1 !== 1'b1 || rdy1 !== 1'b0 || lck0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++; $display("FAIL lock_state got lck1=%b rdy1=%b lck0=%b rdy0=%b want 1 0 0 1",
                      lck1, rdy1, lck0, rdy0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, i == 7, 1'b0, 1'b0);
      if (rdy1 !== 1'b0 || we1 !== 1'b0 || lck1 !== 1'b1 || busy1 !== 1'b0 || lck0 !== 1'b0) leaks++;
    end
    total++;
    if (leaks != 0) begin
      bad++; $display("FAIL lock_hold got %0d bad cycles want 0", leaks);
    end
    @(negedge clk);
    vld = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if (lck1 !== 1'b0 || rdy1 !== 1'b1) begin
      bad++; $display("FAIL lock_reset got lck=%b rdy=%b want 0 1", lck1, rdy1);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_abort();
    test_random();
    test_reset_mid();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
